// File: rtl/count_display_driver_if.sv
// Display-side bundle: counter value and blank request in, multiplexed display and wrap flags out.
interface count_display_driver_if;
   logic [3:0] Count;
   logic       Blank;
   logic [6:0] Seg;
   logic [1:0] An;
   logic       WrapUp;
   logic       WrapDown;

   modport master (output Count, Blank, input Seg, An, WrapUp, WrapDown);
   modport slave  (input Count, Blank, output Seg, An, WrapUp, WrapDown);
endinterface

// File: rtl/count_display_driver.sv
// Two-digit multiplexed 7-segment driver for a 0-15 counter, with wrap-around pulse flags.
module count_display_driver #(
   parameter int unsigned REFRESH_DIV    = 50000,
   parameter int unsigned DEAD           = 4,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
   input logic                   Clk,
   input logic                   reset_n,
   count_display_driver_if.slave bus
);

   localparam int unsigned     PscW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PscW-1:0] PscMax = PscW'(REFRESH_DIV - 1);
   localparam logic [6:0]      SegOff = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [1:0]      AnOff  = DIG_ACTIVE_LOW ? 2'b11 : 2'b00;

   // Active-high gfedcba pattern for one decimal digit.
   function automatic logic [6:0] seg_enc(input logic [3:0] d);
      case (d)
         4'd0:    seg_enc = 7'h3F;
         4'd1:    seg_enc = 7'h06;
         4'd2:    seg_enc = 7'h5B;
         4'd3:    seg_enc = 7'h4F;
         4'd4:    seg_enc = 7'h66;
         4'd5:    seg_enc = 7'h6D;
         4'd6:    seg_enc = 7'h7D;
         4'd7:    seg_enc = 7'h07;
         4'd8:    seg_enc = 7'h7F;
         4'd9:    seg_enc = 7'h6F;
         default: seg_enc = 7'h00;
      endcase
   endfunction

   logic [3:0]      cnt_q, cnt_d;
   logic [3:0]      cnt_prev_q, cnt_prev_d;
   logic            valid_q;
   logic            wrap_up_q, wrap_up_d;
   logic            wrap_dn_q, wrap_dn_d;
   logic [PscW-1:0] psc_q, psc_d;
   logic            slot_q, slot_d;
   logic [3:0]      disp_q, disp_d;
   logic [6:0]      seg_q, seg_d;
   logic [1:0]      an_q, an_d;

   logic       psc_wrap;
   logic       in_dead;
   logic       tens;
   logic [3:0] ones;

   // Sampling, wrap detection, scan counters and frame-boundary display load.
   always_comb begin
      cnt_d      = bus.Count;
      // First sample seeds the history so it is never compared against the reset value.
      cnt_prev_d = valid_q ? cnt_q : bus.Count;
      wrap_up_d  = valid_q && (cnt_prev_q == 4'd15) && (cnt_q == 4'd0);
      wrap_dn_d  = valid_q && (cnt_prev_q == 4'd0) && (cnt_q == 4'd15);
      psc_wrap   = (psc_q == PscMax);
      psc_d      = psc_wrap ? '0 : psc_q + 1'b1;
      slot_d     = psc_wrap ? ~slot_q : slot_q;
      // Load only at the end of the tens slot so both digits come from the same frame.
      disp_d     = (psc_wrap && slot_q) ? cnt_q : disp_q;
   end

   // Digit split and registered segment/anode drive for the current slot.
   always_comb begin
      in_dead = (32'(psc_q) < DEAD);
      tens    = (disp_q >= 4'd10);
      ones    = tens ? disp_q - 4'd10 : disp_q;
      seg_d   = SegOff;
      an_d    = AnOff;
      if (!bus.Blank && !in_dead) begin
         if (!slot_q) begin
            seg_d = seg_enc(ones) ^ SegOff;
            an_d  = AnOff ^ 2'b01;
         end else if (tens) begin
            seg_d = seg_enc(4'd1) ^ SegOff;
            an_d  = AnOff ^ 2'b10;
         end
      end
   end

   // State register with asynchronous clear.
   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q      <= 4'd0;
         cnt_prev_q <= 4'd0;
         valid_q    <= 1'b0;
         wrap_up_q  <= 1'b0;
         wrap_dn_q  <= 1'b0;
         psc_q      <= '0;
         slot_q     <= 1'b0;
         disp_q     <= 4'd0;
         seg_q      <= SegOff;
         an_q       <= AnOff;
      end else begin
         cnt_q      <= cnt_d;
         cnt_prev_q <= cnt_prev_d;
         valid_q    <= 1'b1;
         wrap_up_q  <= wrap_up_d;
         wrap_dn_q  <= wrap_dn_d;
         psc_q      <= psc_d;
         slot_q     <= slot_d;
         disp_q     <= disp_d;
         seg_q      <= seg_d;
         an_q       <= an_d;
      end
   end

   assign bus.Seg      = seg_q;
   assign bus.An       = an_q;
   assign bus.WrapUp   = wrap_up_q;
   assign bus.WrapDown = wrap_dn_q;

endmodule

// File: tb/tb_count_display_driver.sv
// Directed bench for count_display_driver with an 8-cycle slot and 2-cycle dead time.
module tb_count_display_driver;

   logic clk = 1'b0;
   logic rst_n;
   int   n_pass  = 0;
   int   n_fail  = 0;
   int   n_total = 0;
   int   edge_n  = 0;

   always #5 clk = ~clk;

   count_display_driver_if dif ();

   count_display_driver #(
      .REFRESH_DIV    (8),
      .DEAD           (2),
      .SEG_ACTIVE_LOW (1'b1),
      .DIG_ACTIVE_LOW (1'b1)
   ) dut (
      .Clk     (clk),
      .reset_n (rst_n),
      .bus     (dif.slave)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_disp(input string tag, input logic [1:0] an, input logic [6:0] seg);
      check({tag, "_an"}, 8'(dif.An), 8'(an));
      check({tag, "_seg"}, 8'(dif.Seg), 8'(seg));
   endtask

   task automatic chk_wrap(input string tag, input logic up, input logic dn);
      check({tag, "_up"}, 8'(dif.WrapUp), 8'(up));
      check({tag, "_dn"}, 8'(dif.WrapDown), 8'(dn));
   endtask

   // One rising edge, then settle 1ns past it.
   task automatic tick();
      @(posedge clk);
      #1;
      edge_n++;
   endtask

   task automatic run_to(input int k);
      while (edge_n < k) tick();
   endtask

   initial begin
      rst_n     = 1'b1;
      dif.Count = 4'd7;
      dif.Blank = 1'b0;

      // Asynchronous reset mid-cycle.
      #12 rst_n = 1'b0;
      #1;
      chk_disp("rst", 2'b11, 7'h7F);
      chk_wrap("rst", 1'b0, 1'b0);

      dif.Count = 4'd0;
      @(negedge clk);
      rst_n  = 1'b1;
      edge_n = 0;

      // Count=0: first frame shows "0" on ones, tens blanked.
      tick();
      chk_disp("a_dead", 2'b11, 7'h7F);
      chk_wrap("a_first", 1'b0, 1'b0);
      run_to(3);
      chk_disp("a_ones0", 2'b10, 7'h40);
      chk_wrap("a_nowrap", 1'b0, 1'b0);
      run_to(11);
      chk_disp("a_tensblank", 2'b11, 7'h7F);

      // Display 13.
      dif.Count = 4'd13;
      run_to(17);
      chk_disp("b_dead0", 2'b11, 7'h7F);
      run_to(19);
      chk_disp("b_ones3", 2'b10, 7'h30);
      run_to(25);
      chk_disp("b_dead1", 2'b11, 7'h7F);
      run_to(27);
      chk_disp("b_tens1", 2'b01, 7'h79);
      run_to(35);
      chk_disp("b_frame2", 2'b10, 7'h30);

      // Wrap up: 14,15,0,1.
      dif.Count = 4'd14;
      tick();
      dif.Count = 4'd15;
      tick();
      dif.Count = 4'd0;
      tick();
      chk_wrap("c_pre", 1'b0, 1'b0);
      dif.Count = 4'd1;
      tick();
      chk_wrap("c_pulse", 1'b1, 1'b0);
      tick();
      chk_wrap("c_after", 1'b0, 1'b0);

      // Wrap down: 1,0,15.
      dif.Count = 4'd0;
      tick();
      dif.Count = 4'd15;
      tick();
      chk_wrap("d_pre", 1'b0, 1'b0);
      tick();
      chk_wrap("d_pulse", 1'b0, 1'b1);
      tick();
      chk_wrap("d_after", 1'b0, 1'b0);

      // 3 -> 9 is not a wrap.
      dif.Count = 4'd3;
      tick();
      dif.Count = 4'd9;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_wrap("d_jump", 1'b0, 1'b0);
      end

      // Frame-boundary load: 5 shown for the whole frame, 12 from the next.
      run_to(50);
      dif.Count = 4'd5;
      run_to(68);
      dif.Count = 4'd12;
      run_to(70);
      chk_disp("e_ones5", 2'b10, 7'h12);
      run_to(75);
      chk_disp("e_tensblank", 2'b11, 7'h7F);
      run_to(83);
      chk_disp("e_ones2", 2'b10, 7'h24);
      run_to(91);
      chk_disp("e_tens1", 2'b01, 7'h79);

      // Blank for 20 cycles with a 15->0 wrap inside.
      dif.Blank = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk_disp("f_blank", 2'b11, 7'h7F);
         if (edge_n == 95) dif.Count = 4'd15;
         if (edge_n == 96) dif.Count = 4'd0;
         if (edge_n == 97) check("f_wrap_pre", 8'(dif.WrapUp), 8'h00);
         if (edge_n == 98) check("f_wrap_pulse", 8'(dif.WrapUp), 8'h01);
         if (edge_n == 99) check("f_wrap_after", 8'(dif.WrapUp), 8'h00);
      end
      dif.Blank = 1'b0;
      tick();
      chk_disp("f_resume", 2'b01, 7'h79);
      tick();
      chk_disp("f_resume_dead", 2'b11, 7'h7F);

      // Reset during a WrapUp pulse.
      dif.Count = 4'd15;
      tick();
      dif.Count = 4'd0;
      tick();
      tick();
      chk_wrap("g_pulse", 1'b1, 1'b0);
      #2;
      dif.Count = 4'd7;
      rst_n     = 1'b0;
      #1;
      chk_wrap("g_cut", 1'b0, 1'b0);
      chk_disp("g_rst", 2'b11, 7'h7F);

      // First sample 15 against the cleared history must not flag WrapDown.
      dif.Count = 4'd15;
      @(posedge clk);
      @(negedge clk);
      rst_n  = 1'b1;
      edge_n = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_wrap("g_first", 1'b0, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
